// File: rtl/pkt_send_module_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pkt_send_module_pkg
// Brief    : Shared widths, header field offsets and word builders for the
//            per-port packet generator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package pkt_send_module_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int PORT_NUB_TOTAL  = 16;
  localparam int DATA_LENGTH_MAX = 1024;
  localparam int PRIORITY        = 8;

  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY);

  localparam int PERIOD_WIDTH  = 20;
  localparam int SEQ_WIDTH     = 8;
  localparam int SRC_WIDTH     = 8;

  // Header word is packed LSB-first: dest, priority, length, source port.
  localparam int HDR_DEST_LSB = 0;
  localparam int HDR_PRI_LSB  = HDR_DEST_LSB + WIDTH_SEL;
  localparam int HDR_LEN_LSB  = HDR_PRI_LSB + WIDTH_PRIORITY;
  localparam int HDR_SRC_LSB  = HDR_LEN_LSB + WIDTH_LENGTH;

  // Payload word: word index in the low half, sequence number above it.
  localparam int PAY_IDX_WIDTH = 16;
  localparam int PAY_SEQ_LSB   = 16;

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [SRC_WIDTH-1:0]      src,
    input logic [WIDTH_LENGTH-1:0]   len,
    input logic [WIDTH_PRIORITY-1:0] pri,
    input logic [WIDTH_SEL-1:0]      dst
  );
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    word[HDR_DEST_LSB +: WIDTH_SEL]      = dst;
    word[HDR_PRI_LSB  +: WIDTH_PRIORITY] = pri;
    word[HDR_LEN_LSB  +: WIDTH_LENGTH]   = len;
    word[HDR_SRC_LSB  +: SRC_WIDTH]      = src;
    return word;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_payload(
    input logic [SEQ_WIDTH-1:0]    seq,
    input logic [WIDTH_LENGTH-1:0] idx
  );
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    word[PAY_SEQ_LSB +: SEQ_WIDTH] = seq;
    word[0 +: PAY_IDX_WIDTH]       = PAY_IDX_WIDTH'(idx);
    return word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_send_module_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : send_period_timer
// Brief    : Free-running sop-to-sop period counter; flags when the
//            programmed period has elapsed since the last clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module send_period_timer
  import pkt_send_module_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    elapsed
);

  logic [PERIOD_WIDTH-1:0] count;

  // Count cycles since the last clear; saturate so a long idle never wraps.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + PERIOD_WIDTH'(1);
    end
  end

  // Count is cleared in the sop cycle, so count+1 reaching period means the
  // next cycle is exactly one period after that sop.
  assign elapsed = ({1'b0, count} + (PERIOD_WIDTH + 1)'(1)) >= {1'b0, period};

endmodule
`default_nettype wire

// File: rtl/pkt_send_module.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pkt_send_module
// Brief    : Per-port traffic generator: header word plus `length` payload
//            words on a sop/vld/eop write port, single-shot or periodic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pkt_send_module
  import pkt_send_module_pkg::*;
#(
  parameter int tx_port = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      single,
  input  logic [PERIOD_WIDTH-1:0]   send_cycle,
  input  logic [WIDTH_SEL-1:0]      dest,
  // "priority" is a reserved word, hence the prefix.
  input  logic [WIDTH_PRIORITY-1:0] pkt_priority,
  input  logic [WIDTH_LENGTH-1:0]   length,
  output logic                      ready,
  output logic                      done,
  output logic                      wr_sop,
  output logic                      wr_eop,
  output logic                      wr_vld,
  output logic [DATA_WIDTH-1:0]     wr_data
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOP  = 3'd1,
    ST_HEAD = 3'd2,
    ST_DATA = 3'd3,
    ST_EOP  = 3'd4,
    ST_GAP  = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  localparam logic [SRC_WIDTH-1:0]    TX_ID   = SRC_WIDTH'(tx_port);
  localparam logic [WIDTH_LENGTH-1:0] LEN_ONE = WIDTH_LENGTH'(1);

  state_t                    state, state_next;
  logic [WIDTH_LENGTH-1:0]   word_idx, idx_next;
  logic [SEQ_WIDTH-1:0]      seq;
  logic [WIDTH_SEL-1:0]      dest_q;
  logic [WIDTH_PRIORITY-1:0] pri_q;
  logic [WIDTH_LENGTH-1:0]   len_q;
  logic                      single_q;
  logic [PERIOD_WIDTH-1:0]   cycle_q;
  logic                      timer_clear;
  logic                      period_done;

  send_period_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .period  (cycle_q),
    .elapsed (period_done)
  );

  // Next-state and payload index; start is observed live, mode is latched.
  always_comb begin
    state_next = state;
    idx_next   = word_idx;
    case (state)
      ST_IDLE: if (start) state_next = ST_SOP;
      ST_SOP:  state_next = ST_HEAD;
      ST_HEAD: begin
        idx_next   = '0;
        state_next = (len_q == '0) ? ST_EOP : ST_DATA;
      end
      ST_DATA: begin
        if (word_idx == len_q - LEN_ONE) state_next = ST_EOP;
        else                             idx_next   = word_idx + LEN_ONE;
      end
      ST_EOP: begin
        if (single_q)   state_next = ST_HOLD;
        else if (start) state_next = ST_GAP;
        else            state_next = ST_IDLE;
      end
      // An overrun period has already elapsed on the first GAP cycle, which
      // yields the one-cycle minimum gap.
      ST_GAP: begin
        if (!start)           state_next = ST_IDLE;
        else if (period_done) state_next = ST_SOP;
      end
      ST_HOLD: if (!start) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The period is measured from each sop.
  assign timer_clear = (state_next == ST_SOP);

  // State, latched request fields, sequence number and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= ST_IDLE;
      word_idx <= '0;
      seq      <= '0;
      dest_q   <= '0;
      pri_q    <= '0;
      len_q    <= '0;
      single_q <= 1'b0;
      cycle_q  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      wr_sop   <= 1'b0;
      wr_eop   <= 1'b0;
      wr_vld   <= 1'b0;
      wr_data  <= '0;
    end else begin
      state    <= state_next;
      word_idx <= idx_next;
      if (state == ST_IDLE && start) begin
        dest_q   <= dest;
        pri_q    <= pkt_priority;
        len_q    <= length;
        single_q <= single;
        cycle_q  <= send_cycle;
      end
      if (state == ST_EOP) seq <= seq + SEQ_WIDTH'(1);
      ready  <= (state_next == ST_IDLE);
      done   <= (state == ST_EOP);
      wr_sop <= (state_next == ST_SOP);
      wr_eop <= (state_next == ST_EOP);
      wr_vld <= (state_next == ST_HEAD) || (state_next == ST_DATA);
      case (state_next)
        ST_HEAD: wr_data <= make_header(TX_ID, len_q, pri_q, dest_q);
        ST_DATA: wr_data <= make_payload(seq, idx_next);
        default: wr_data <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_send_module.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pkt_send_module
// Brief    : Self-checking bench for pkt_send_module: table of request
//            scenarios feeding an event scoreboard, plus reset sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pkt_send_module;

  localparam int TX_PORT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        single = 1'b0;
  logic [19:0] send_cycle = '0;
  logic [3:0]  dest = '0;
  logic [2:0]  pkt_priority = '0;
  logic [9:0]  length = '0;
  logic        ready, done, wr_sop, wr_eop, wr_vld;
  logic [31:0] wr_data;

  pkt_send_module #(.tx_port(TX_PORT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .single       (single),
    .send_cycle   (send_cycle),
    .dest         (dest),
    .pkt_priority (pkt_priority),
    .length       (length),
    .ready        (ready),
    .done         (done),
    .wr_sop       (wr_sop),
    .wr_eop       (wr_eop),
    .wr_vld       (wr_vld),
    .wr_data      (wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_seq = 8'd0;

  // flags = {sop, vld, eop, done}
  typedef struct {
    int          cyc;
    logic [3:0]  flags;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic        single;
    logic [3:0]  dest;
    logic [2:0]  pri;
    logic [9:0]  len;
    logic [19:0] sc;
    int          hold;
    int          npkt;
    int          period;
  } case_t;
  case_t cases[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] hdr_word(input logic [3:0] d, input logic [2:0] p, input logic [9:0] l);
    return 32'(d) | (32'(p) << 4) | (32'(l) << 7) | (32'(TX_PORT) << 17);
  endfunction

  function automatic logic [31:0] pay_word(input logic [7:0] s, input int k);
    return (32'(s) << 16) | 32'(k);
  endfunction

  task automatic push_packet(input int t0, input case_t r, input logic [7:0] s);
    ev_t e;
    e.cyc = t0;     e.flags = 4'b1000; e.data = '0; exp_q.push_back(e);
    e.cyc = t0 + 1; e.flags = 4'b0100; e.data = hdr_word(r.dest, r.pri, r.len); exp_q.push_back(e);
    for (int k = 0; k < int'(r.len); k++) begin
      e.cyc = t0 + 2 + k; e.data = pay_word(s, k); exp_q.push_back(e);
    end
    e.cyc = t0 + 2 + int'(r.len); e.flags = 4'b0010; e.data = '0; exp_q.push_back(e);
    e.cyc = t0 + 3 + int'(r.len); e.flags = 4'b0001; exp_q.push_back(e);
  endtask

  // Monitor: every active output cycle is matched against the scoreboard.
  logic [3:0] obs_flags;
  ev_t        obs_e;
  always @(negedge clk) begin
    if (mon_en) begin
      obs_flags = {wr_sop, wr_vld, wr_eop, done};
      check("sop_vld_eop_exclusive", 32'($countones({wr_sop, wr_vld, wr_eop}) <= 1), 32'd1);
      if (obs_flags != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_flags", 32'(obs_flags), 32'd0);
        end else begin
          obs_e = exp_q.pop_front();
          check("event_cycle", 32'(cyc), 32'(obs_e.cyc));
          check("event_flags", 32'(obs_flags), 32'(obs_e.flags));
          if (obs_e.flags[2]) check("event_data", wr_data, obs_e.data);
        end
      end
    end
  end

  task automatic wait_ready();
    int waited = 0;
    while (ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
  endtask

  task automatic run_case(input case_t r);
    int t0;
    int waited;
    wait_ready();
    single = r.single; dest = r.dest; pkt_priority = r.pri;
    length = r.len; send_cycle = r.sc; start = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < r.npkt; k++) begin
      push_packet(t0 + k * r.period, r, exp_seq);
      exp_seq = exp_seq + 8'd1;
    end
    @(posedge clk); #1;
    // Inputs changed after the request was taken must have no effect.
    single = ~r.single; dest = ~r.dest; pkt_priority = ~r.pri;
    length = 10'($urandom_range(0, 1023)); send_cycle = 20'($urandom_range(0, 40));
    repeat (r.hold - 1) @(posedge clk);
    #1;
    check("ready_while_busy", 32'(ready), 32'd0);
    start = 1'b0;
    waited = 0;
    while ((exp_q.size() != 0 || ready !== 1'b1) && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("ready_after_drain", 32'(ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   32'(ready),  32'd1);
    check({tag, "_done"},    32'(done),   32'd0);
    check({tag, "_wr_sop"},  32'(wr_sop), 32'd0);
    check({tag, "_wr_eop"},  32'(wr_eop), 32'd0);
    check({tag, "_wr_vld"},  32'(wr_vld), 32'd0);
    check({tag, "_wr_data"}, wr_data,     32'd0);
  endtask

  initial begin
    case_t rr;
    //             single dest   pri   len      sc      hold npkt period
    cases[0] = '{1'b0, 4'd2,  3'd2, 10'd10,   20'd20, 50, 3, 20};  // periodic, drop mid-packet
    cases[1] = '{1'b1, 4'd5,  3'd7, 10'd3,    20'd20, 50, 1, 0};   // single, held start
    cases[2] = '{1'b1, 4'd15, 3'd0, 10'd0,    20'd20, 10, 1, 0};   // zero payload
    cases[3] = '{1'b0, 4'd1,  3'd3, 10'd10,   20'd5,  40, 3, 14};  // overrun: sop at eop+2
    cases[4] = '{1'b0, 4'd9,  3'd4, 10'd1023, 20'd0,  5,  1, 0};   // maximum length
    cases[5] = '{1'b0, 4'd3,  3'd1, 10'd4,    20'd8,  30, 4, 8};   // period = len+4
    cases[6] = '{1'b0, 4'd4,  3'd6, 10'd4,    20'd7,  30, 4, 8};   // period = len+3 (overrun)
    cases[7] = '{1'b0, 4'd6,  3'd5, 10'd2,    20'd30, 15, 1, 30};  // drop during gap

    repeat (10) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_case(cases[i]);

    // Reset in the middle of the payload abandons the packet with no eop.
    mon_en = 1'b0;
    exp_q.delete();
    wait_ready();
    single = 1'b0; dest = 4'd1; pkt_priority = 3'd1; length = 10'd10; send_cycle = 20'd20;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_payload_vld", 32'(wr_vld), 32'd1);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Sequence number restarts from zero after reset.
    exp_seq = 8'd0;
    rr = '{1'b1, 4'd7, 3'd3, 10'd5, 20'd20, 10, 1, 0};
    run_case(rr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
